// File: rtl/sdram_replay_sched_if.sv
// sdram_replay_sched_if: host command and SDRAM handler register-bus signals for the replay scheduler
interface sdram_replay_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [23:0] cmd_len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [23:0] words_left;
  logic        rd_beat;
  logic        h_avalid;
  logic        h_awe;
  logic        h_aaddr;
  logic [31:0] h_adata;
  logic        h_bvalid;
  logic [31:0] h_bdata;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, abort, rd_beat, h_bvalid, h_bdata,
    output cmd_ready, busy, done, words_left, h_avalid, h_awe, h_aaddr, h_adata
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, abort, rd_beat, h_bvalid, h_bdata,
    input  cmd_ready, busy, done, words_left, h_avalid, h_awe, h_aaddr, h_adata
  );
endinterface

// File: rtl/sdram_replay_sched.sv
// sdram_replay_sched: replays captured SDRAM words in chunks that the handler has already written
module sdram_replay_sched #(
  parameter int CHUNK_MAX = 4095
) (
  input logic clk,
  input logic rst,
  sdram_replay_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, POLL, WAIT_ST, SET_ADDR, SET_CNT, DRAIN, FINISH, CANCEL} state_t;
  state_t state, nxt;
  logic [23:0] cur_addr, left, avail, lim, n_calc;
  logic [11:0] n, beats;
  logic        cmd_ready, busy, done, h_avalid, h_awe, h_aaddr;
  logic [31:0] h_adata;
  logic        accept, last_beat, kill, issue;
  logic        unused;
  assign unused = ^bus.h_bdata[31:24];
  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.words_left = left;
  assign bus.h_avalid   = h_avalid;
  assign bus.h_awe      = h_awe;
  assign bus.h_aaddr    = h_aaddr;
  assign bus.h_adata    = h_adata;
  always_comb begin
    accept    = state == IDLE && bus.cmd_valid && cmd_ready;
    kill      = state != IDLE && bus.abort;
    avail     = bus.h_bdata[23:0] - cur_addr;
    lim       = left < 24'(CHUNK_MAX) ? left : 24'(CHUNK_MAX);
    n_calc    = lim < avail ? lim : avail;
    last_beat = bus.rd_beat && (beats + 12'd1 == n);
    issue     = (state == POLL || state == SET_ADDR || state == SET_CNT) && !kill;
    nxt       = state;
    case (state)
      IDLE:     if (accept) nxt = bus.cmd_len == 24'd0 ? FINISH : POLL;
      POLL:     nxt = WAIT_ST;
      WAIT_ST:  if (bus.h_bvalid) nxt = n_calc == 24'd0 ? POLL : SET_ADDR;
      SET_ADDR: nxt = SET_CNT;
      SET_CNT:  nxt = DRAIN;
      DRAIN:    if (last_beat) nxt = left == {12'h0, n} ? FINISH : POLL;
      default:  nxt = IDLE;
    endcase
    // abort outranks everything; once a count may be live in the handler it must be zeroed
    if (kill) nxt = (state == SET_CNT || state == DRAIN) ? CANCEL : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      left      <= '0;
      cur_addr  <= '0;
      n         <= '0;
      beats     <= '0;
      h_avalid  <= 1'b0;
      h_awe     <= 1'b0;
      h_aaddr   <= 1'b0;
      h_adata   <= '0;
    end else begin
      state     <= nxt;
      cmd_ready <= nxt == IDLE;
      busy      <= nxt != IDLE;
      done      <= state == FINISH && !kill;
      h_avalid  <= issue || state == CANCEL;
      h_awe     <= (issue && state != POLL) || state == CANCEL;
      h_aaddr   <= (issue && state == SET_CNT) || state == CANCEL;
      h_adata   <= !issue ? 32'h0 : state == SET_ADDR ? {8'h00, cur_addr} : state == SET_CNT ? {20'h0, n} : 32'h0;
      if (accept) begin
        cur_addr <= bus.cmd_addr;
        left     <= bus.cmd_len;
      end
      if (state == WAIT_ST && bus.h_bvalid) n <= n_calc[11:0];
      if (state == SET_CNT) beats <= '0;
      if (state == DRAIN && bus.rd_beat && !kill) begin
        beats <= beats + 12'd1;
        if (last_beat) begin
          cur_addr <= cur_addr + {12'h0, n};
          left     <= left - {12'h0, n};
        end
      end
      if (kill) left <= '0;
    end
  end
endmodule

// File: tb/tb_sdram_replay_sched.sv
// tb_sdram_replay_sched: handler model plus write scoreboard driving the replay scheduler
module tb_sdram_replay_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sdram_replay_sched_if bus();
  sdram_replay_sched #(.CHUNK_MAX(4095)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [32:0] exp_q[$];
  int polls = 0, stall = 0, stall2 = 0, first_wr_polls = -1;
  logic [23:0] wp_early = '0, wp_mid = '0, wp_late = '0, resp = '0;
  int remaining = 0, beat_total = 0, beat_stop = 1 << 30;
  int done_cnt = 0, avalid_cnt = 0;
  logic pend = 1'b0, extra_beat = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_wr(input logic a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask
  // handler model: answers status reads one cycle late, feeds beats up to the programmed count
  always @(negedge clk) begin
    logic [32:0] e;
    bus.h_bvalid = pend;
    bus.h_bdata  = {8'h80, resp};
    pend = 1'b0;
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.h_avalid) begin
        avalid_cnt++;
        if (!bus.h_awe) begin
          resp = polls < stall ? wp_early : polls < stall2 ? wp_mid : wp_late;
          polls++;
          pend = 1'b1;
        end else begin
          if (first_wr_polls < 0) first_wr_polls = polls;
          e = exp_q.size() != 0 ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
          chk("hwr", {31'h0, bus.h_aaddr, bus.h_adata}, {31'h0, e});
          if (bus.h_aaddr) remaining = int'(bus.h_adata[11:0]);
        end
      end
    end
    if (remaining > 0 && beat_total < beat_stop) begin
      bus.rd_beat = 1'b1;
      remaining--;
      beat_total++;
    end else bus.rd_beat = extra_beat;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [23:0] a, input logic [23:0] l);
    int t = 0;
    while (!bus.cmd_ready && t < 50) begin
      tick();
      t++;
    end
    chk("cmd_ready_wait", {63'h0, bus.cmd_ready}, 64'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk(tag, 64'(done_cnt - d0), 64'h1);
  endtask
  task automatic set_wp(input int s, input int s2, input logic [23:0] e, input logic [23:0] m, input logic [23:0] l);
    stall = s; stall2 = s2; wp_early = e; wp_mid = m; wp_late = l;
    polls = 0; first_wr_polls = -1;
  endtask
  initial begin
    int d0, a0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.abort = 1'b0;
    bus.rd_beat = 1'b0; bus.h_bvalid = 1'b0; bus.h_bdata = '0;
    tick();
    chk("rst_ready", {63'h0, bus.cmd_ready}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_state", {bus.cmd_ready, bus.busy, bus.done, bus.h_avalid, bus.h_awe, bus.h_aaddr, bus.words_left, bus.h_adata},
        {1'b1, 5'b0, 24'h0, 32'h0});
    // single chunk
    set_wp(0, 0, 0, 0, 24'h000200);
    expect_wr(1'b0, 32'h0000_0100);
    expect_wr(1'b1, 32'h0000_0010);
    send(24'h000100, 24'd16);
    chk("t1_busy", {bus.busy, bus.cmd_ready, bus.words_left}, {2'b10, 24'd16});
    wait_done("t1_done", 300);
    chk("t1_end", {bus.cmd_ready, bus.words_left}, {1'b1, 24'h0});
    chk("t1_polls", 64'(polls), 64'd1);
    chk("t1_q", 64'(exp_q.size()), 64'd0);
    // three chunks capped at CHUNK_MAX
    set_wp(0, 0, 0, 0, 24'h800000);
    expect_wr(1'b0, 32'h0000_1000);
    expect_wr(1'b1, 32'd4095);
    expect_wr(1'b0, 32'h0000_1000 + 32'd4095);
    expect_wr(1'b1, 32'd4095);
    expect_wr(1'b0, 32'h0000_1000 + 32'd8190);
    expect_wr(1'b1, 32'd1810);
    send(24'h001000, 24'd10000);
    wait_done("t2_done", 12000);
    chk("t2_left", 64'(bus.words_left), 64'h0);
    chk("t2_addr", 64'(dut.cur_addr), 64'h1000 + 64'd10000);
    chk("t2_q", 64'(exp_q.size()), 64'd0);
    // stalled write pointer
    set_wp(5, 8, 24'h000050, 24'h000070, 24'h0000B4);
    expect_wr(1'b0, 32'h0000_0050);
    expect_wr(1'b1, 32'h0000_0020);
    expect_wr(1'b0, 32'h0000_0070);
    expect_wr(1'b1, 32'h0000_0044);
    send(24'h000050, 24'd100);
    wait_done("t3_done", 600);
    chk("t3_first_wr_polls", 64'(first_wr_polls), 64'd6);
    chk("t3_polls", 64'(polls), 64'd9);
    chk("t3_q", 64'(exp_q.size()), 64'd0);
    // address wrap
    set_wp(0, 0, 0, 0, 24'h000010);
    expect_wr(1'b0, 32'h00FF_FFF0);
    expect_wr(1'b1, 32'h0000_0020);
    send(24'hFFFFF0, 24'd32);
    wait_done("t4_done", 300);
    chk("t4_addr", 64'(dut.cur_addr), 64'h10);
    chk("t4_q", 64'(exp_q.size()), 64'd0);
    // abort in DRAIN after 5 beats
    set_wp(0, 0, 0, 0, 24'h001000);
    beat_stop = beat_total + 5;
    expect_wr(1'b0, 32'h0000_0300);
    expect_wr(1'b1, 32'h0000_0010);
    expect_wr(1'b1, 32'h0000_0000);
    d0 = done_cnt;
    send(24'h000300, 24'd16);
    for (int i = 0; i < 100 && beat_total < beat_stop; i++) tick();
    chk("t5_beats", 64'(beat_total), 64'(beat_stop));
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_left", 64'(bus.words_left), 64'h0);
    repeat (3) tick();
    extra_beat = 1'b1;
    tick();
    extra_beat = 1'b0;
    repeat (2) tick();
    chk("t5_idle", {bus.cmd_ready, bus.busy, bus.words_left, dut.cur_addr}, {2'b10, 24'h0, 24'h000300});
    chk("t5_nodone", 64'(done_cnt - d0), 64'h0);
    chk("t5_q", 64'(exp_q.size()), 64'd0);
    beat_stop = 1 << 30;
    remaining = 0;
    // zero-length command
    a0 = avalid_cnt;
    while (!bus.cmd_ready) tick();
    bus.cmd_valid = 1'b1; bus.cmd_addr = 24'h000123; bus.cmd_len = 24'd0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("t6_done_c1", {63'h0, bus.done}, 64'h0);
    tick();
    chk("t6_done_c2", {63'h0, bus.done}, 64'h1);
    tick();
    chk("t6_done_c3", {bus.done, bus.cmd_ready}, 2'b01);
    chk("t6_no_bus", 64'(avalid_cnt - a0), 64'h0);
    // abort while waiting for status
    set_wp(0, 0, 0, 0, 24'h001000);
    d0 = done_cnt;
    send(24'h000010, 24'd16);
    tick();
    chk("t7_poll", {bus.h_avalid, bus.h_awe}, 2'b10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (4) tick();
    chk("t7_idle", {bus.cmd_ready, bus.busy, bus.h_avalid, bus.words_left}, {3'b100, 24'h0});
    chk("t7_nodone", 64'(done_cnt - d0), 64'h0);
    chk("t7_polls", 64'(polls), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdram_replay_sched.md
Name: sdram_replay_sched

Overview:
- Sequences readback from the SDRAM capture buffer by driving the capture handler's register bus.
- Accepts a host command (start word address, length), polls the handler's write-pointer status, and programs read address/count in chunks.
- Issues a chunk only once that data has been written.
- Counts delivered read beats, then advances to the next chunk. Sits between the host command path and the SDRAM handler's avalid/awe/aaddr/adata/bvalid/bdata port.

Parameters:
- CHUNK_MAX, 4095, largest read count programmed per chunk; must be ≤ 4095 (handler count register is 12 bits).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  24  first word address.
- cmd_len  in  24  words to replay; 0 is legal.
- abort  in  1  cancel current command.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes normally (not on abort).
- words_left  out  24  remaining words of current command.
- rd_beat  in  1  one pulse per word delivered by the handler to the read FIFO.
- h_avalid  out  1  handler bus request, one cycle per access.
- h_awe  out  1  1 = register write, 0 = status read.
- h_aaddr  out  1  0 = read address register, 1 = read count register.
- h_adata  out  32  write data.
- h_bvalid  in  1  handler response valid (handler answers one cycle after h_avalid).
- h_bdata  in  32  handler status: bit 31 = writes pending, bits 23:0 = written-word pointer wp.

Behaviour:
- Reset values: cmd_ready=0 for the reset cycle, then 1. busy=0, done=0, words_left=0, h_avalid=0, h_awe=0, h_aaddr=0, h_adata=0. State=IDLE. Internal cur_addr=0, chunk n=0, beat counter=0.
- All h_* outputs are registered. h_avalid is high for exactly one cycle per access; h_awe, h_aaddr and h_adata are valid in that cycle.
- IDLE: on accept, latch cur_addr=cmd_addr and words_left=cmd_len.
  - If cmd_len=0, go to FINISH (no bus traffic).
  - Otherwise go to POLL.
- POLL: issue a status read (h_avalid=1, h_awe=0), then go to WAIT_ST.
- WAIT_ST: hold until h_bvalid, then latch wp=h_bdata[23:0] and compute:
  - avail = (wp − cur_addr) mod 2^24, a 24-bit wrapping subtract.
  - n = min(words_left, CHUNK_MAX, avail).
  - If n=0, return to POLL (re-poll; back-to-back polls are allowed). Otherwise go to SET_ADDR.
- SET_ADDR: write h_aaddr=0, h_adata={8'h00, cur_addr}, then go to SET_CNT.
- SET_CNT: write h_aaddr=1, h_adata={20'h0, n[11:0]}, clear beat counter, then go to DRAIN.
- DRAIN: count rd_beat. When the count reaches n:
  - cur_addr += n (mod 2^24) and words_left −= n, in the same cycle as the last beat.
  - If words_left becomes 0, go to FINISH; otherwise go to POLL.
- FINISH: done=1 for one cycle, then go to IDLE.
- rd_beat outside DRAIN is ignored. Beats never exceed n within DRAIN, because the handler stops at its count.
- Abort (highest priority, sampled every non-IDLE cycle):
  - In SET_CNT, or in DRAIN: go to CANCEL. CANCEL writes h_aaddr=1, h_adata=0 (zero the handler's remaining count), then goes to IDLE.
  - In any other non-IDLE state: go to IDLE next cycle.
  - A pending h_bvalid arriving after abort is ignored.
  - words_left clears to 0 on abort. No done pulse.
- cmd_valid while busy is not accepted; the host holds it.
- Address wrap: cur_addr and the avail computation wrap at 2^24. A request more than 2^24−1 words behind wp is unsupported.
- Polling h_bdata[31] is informational only. Availability is decided by wp alone.

Test Plan:
- Reset, then cmd addr=0x000100, len=16, handler status wp=0x000200. Required response:
  - bus sequence: status read, then write aaddr0=0x00000100, then write aaddr1=0x00000010;
  - after 16 rd_beat: done pulse, words_left=0, cmd_ready=1.
- len=10000, wp far ahead: three chunks programmed with counts 4095, 4095, 1810 and addresses start, start+4095, start+8190; done after 10000 beats.
- addr=0x000050, len=100, wp=0x000050 for 5 polls, then wp=0x000070:
  - repeated status reads with no writes while wp=0x000050;
  - then a chunk of 0x20 words at 0x50;
  - after 32 beats, further polling for the remaining 68.
- Wrap: addr=0xFFFFF0, len=32, wp=0x000010: avail=0x20, single chunk count 32 at 0xFFFFF0; cur_addr ends at 0x000010.
- Abort in DRAIN after 5 of 16 beats: next bus access is write aaddr1=0; then IDLE, no done, words_left=0. Extra rd_beat after abort changes nothing.
- cmd_len=0: done pulses 2 cycles after accept with no h_avalid activity. Also: abort during WAIT_ST returns to IDLE, and the late h_bvalid is ignored.
